// File: rtl/eq_compare_stream.sv
// eq_compare_stream
//   Registered byte-equality stage. Operand pairs arrive over a valid/ready
//   handshake. Each accepted pair produces one registered result: the
//   equality flag, the index of the lowest differing bit, and a run-hit flag.
//   The stage also keeps saturating match/miss statistics.
//
// Handshake (both sides): a transfer happens on a rising edge where valid
//   and ready are both 1. A producer holds valid and its payload until that
//   edge. in_ready = !out_valid || out_ready, so the single output register
//   can be drained and reloaded in the same cycle with no bubble.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake for operands a, b
//   clr                 synchronous clear of counters and run state
//   out_valid/out_ready output handshake for out_eq, out_diff_idx, out_run_hit
//   match_cnt/miss_cnt  saturating counts of accepted equal/unequal pairs
module eq_compare_stream #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16,
  parameter int RUN_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_eq,
  output logic [$clog2(WIDTH)-1:0] out_diff_idx,
  output logic                     out_run_hit,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         miss_cnt
);

  localparam int         IDX_W   = $clog2(WIDTH);
  localparam logic [7:0] RUN_MAX = 8'(RUN_LEN);
  localparam logic [7:0] RUN_PRE = 8'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] diff;
  logic             diff_eq;
  logic [IDX_W-1:0] diff_idx;
  logic             accept;
  logic             run_hit;
  logic [7:0]       run_cnt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign diff     = a ^ b;
  assign diff_eq  = (diff == '0);

  // Scan from the top down so the last assignment is the lowest set bit.
  always_comb begin
    diff_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (diff[i]) diff_idx = IDX_W'(i);
    end
  end

  // Hit only on the step from RUN_LEN-1 to RUN_LEN; a clear in the same
  // cycle suppresses it because the pair is not counted.
  assign run_hit = diff_eq && !clr && (run_cnt == RUN_PRE);

  // Output register: reload on accept, otherwise drop valid on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_eq       <= 1'b0;
      out_diff_idx <= '0;
      out_run_hit  <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_eq       <= diff_eq;
      out_diff_idx <= diff_idx;
      out_run_hit  <= run_hit;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Statistics and run state update on input accept, never on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
      run_cnt   <= '0;
    end else if (clr) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
      run_cnt   <= '0;
    end else if (accept) begin
      if (diff_eq) begin
        if (match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
        if (run_cnt != RUN_MAX)   run_cnt   <= run_cnt + 8'd1;
      end else begin
        if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_eq_compare_stream.sv
module tb_eq_compare_stream;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 4;
  localparam int RUN_LEN = 4;
  localparam int IDX_W   = 3;
  localparam int W       = 5;   // {hit, eq, idx}
  localparam int CNT_SAT = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_eq;
  logic [IDX_W-1:0] out_diff_idx;
  logic             out_run_hit;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] miss_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  eq_compare_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RUN_LEN(RUN_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_eq(out_eq), .out_diff_idx(out_diff_idx), .out_run_hit(out_run_hit),
    .match_cnt(match_cnt), .miss_cnt(miss_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending results live in a queue; counters are plain ints saturated with
  // a min(), the run is the number of equals since the last miss or clear.
  logic [W-1:0] exp_q[$];
  int m_match = 0;
  int m_miss  = 0;
  int m_run   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_match = 0;
      m_miss  = 0;
      m_run   = 0;
    end else begin
      bit acc, eq, hit;
      int dv, idx;
      acc = in_valid && ((exp_q.size() == 0) || out_ready);
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (acc) begin
        dv  = int'(a ^ b);
        eq  = (dv == 0);
        idx = eq ? 0 : $clog2(dv & -dv);
        hit = eq && !clr && (m_run == RUN_LEN - 1);
        exp_q.push_back({hit, eq, 3'(idx)});
      end
      if (clr) begin
        m_match = 0;
        m_miss  = 0;
        m_run   = 0;
      end else if (acc) begin
        if (eq) begin
          m_match = (m_match + 1 > CNT_SAT) ? CNT_SAT : m_match + 1;
          m_run   = (m_run + 1 > RUN_LEN) ? RUN_LEN : m_run + 1;
        end else begin
          m_miss = (m_miss + 1 > CNT_SAT) ? CNT_SAT : m_miss + 1;
          m_run  = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
      check("match_cnt", 32'(match_cnt), 32'(m_match));
      check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
      if (exp_q.size() != 0)
        check("result", 32'({out_run_hit, out_eq, out_diff_idx}), 32'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int n = 0;
    a = x;
    b = y;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_timeout", 32'(n < 20), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clr = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] run_a[8] = '{8'h3C, 8'h3C, 8'h3C, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
  logic [7:0] run_b[8] = '{8'h3C, 8'h3C, 8'h3D, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
  logic       run_h[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    // Reset defaults with in_valid held high.
    #1;
    in_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_match", 32'(match_cnt), 32'd0);
    check("rst_miss", 32'(miss_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single compare.
    send(8'hA5, 8'hA5);
    check("single_eq", 32'(out_eq), 32'd1);
    check("single_idx", 32'(out_diff_idx), 32'd0);
    check("single_match", 32'(match_cnt), 32'd1);
    send(8'hA5, 8'hA1);
    check("single2_eq", 32'(out_eq), 32'd0);
    check("single2_idx", 32'(out_diff_idx), 32'd2);
    check("single2_miss", 32'(miss_cnt), 32'd1);
    tick();

    // Back-pressure: hold the first result, then release.
    send(8'h11, 8'h11);
    out_ready = 1'b0;
    a = 8'h10;
    b = 8'h30;
    in_valid = 1'b1;
    repeat (2) begin
      tick();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_eq", 32'(out_eq), 32'd1);
      check("bp_hold_idx", 32'(out_diff_idx), 32'd0);
    end
    out_ready = 1'b1;
    send(8'h10, 8'h30);
    check("bp_p1_idx", 32'(out_diff_idx), 32'd5);
    send(8'h01, 8'h03);
    check("bp_p2_idx", 32'(out_diff_idx), 32'd1);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Run detector.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(run_a[i], run_b[i]);
      check("run_hit", 32'(out_run_hit), 32'(run_h[i]));
    end
    check("run_match", 32'(match_cnt), 32'd7);
    check("run_miss", 32'(miss_cnt), 32'd1);

    // Clear colliding with an accept.
    do_reset();
    repeat (3) send(8'h5A, 8'h5A);
    clr = 1'b1;
    send(8'h5A, 8'h5A);
    clr = 1'b0;
    check("clr_match", 32'(match_cnt), 32'd0);
    check("clr_hit", 32'(out_run_hit), 32'd0);
    check("clr_eq", 32'(out_eq), 32'd1);
    send(8'h77, 8'h77);
    check("clr_after_match", 32'(match_cnt), 32'd1);
    check("clr_after_hit", 32'(out_run_hit), 32'd0);

    // Saturation.
    do_reset();
    for (int i = 0; i < 20; i++) send(8'(i), 8'(i) ^ 8'h80);
    check("sat_miss", 32'(miss_cnt), 32'd15);
    check("sat_idx", 32'(out_diff_idx), 32'd7);

    // Asynchronous reset while a result is stalled.
    send(8'h00, 8'h01);
    out_ready = 1'b0;
    tick();
    check("mid_valid_before", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_match", 32'(match_cnt), 32'd0);
    check("mid_miss", 32'(miss_cnt), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        #2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clr       = ($urandom_range(0, 29) == 0);
      a         = 8'($urandom_range(0, 255));
      b         = ($urandom_range(0, 1) == 0) ? a : 8'($urandom_range(0, 255));
      tick();
    end
    in_valid = 1'b0;
    clr = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eq_compare_stream.md
# eq_compare_stream

Streaming, registered byte-equality stage that consumes operand pairs over a valid/ready handshake and produces one registered compare result per accepted pair. It is the sequential consumer of the 8-bit equality function. It adds:
- the index of the first differing bit,
- saturating match/mismatch statistics,
- a consecutive-match run detector.

It sits between an operand source and any downstream logic that needs back-pressured, cycle-aligned equality results.

## Interface
Parameters:
- WIDTH, 8, operand width; power of two, >= 2
- CNT_W, 16, width of each statistics counter
- RUN_LEN, 4, consecutive-match count that fires out_run_hit; 1 <= RUN_LEN <= 255

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept a pair
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- clr  input  1  synchronous clear of counters and run state
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_eq  output  1  1 when a == b for this result
- out_diff_idx  output  log2(WIDTH)  lowest bit index where a != b; 0 when equal
- out_run_hit  output  1  this result completed a run of RUN_LEN consecutive matches
- match_cnt  output  CNT_W  accepted pairs with a == b
- miss_cnt  output  CNT_W  accepted pairs with a != b

## Operation
- **Accept:** a pair is accepted when in_valid && in_ready.
- **Readiness:** in_ready = !out_valid || out_ready. It is combinational from the output register state; this is a one-entry pipeline with no bubble under continuous flow.
- **Result capture:** on accept, the stage computes diff = a ^ b.
  - out_eq = (diff == 0).
  - out_diff_idx = position of the least-significant set bit of diff; 0 when diff == 0.
  - Both are registered into the output register and out_valid is set.
- **Drain:** out_valid clears when out_ready is high and no new pair is accepted in the same cycle. Simultaneous drain and accept reloads the register; out_valid stays 1.
- **Hold:** while out_valid && !out_ready, the output fields are held stable and in_ready = 0.
- **Statistics:**
  - match_cnt increments on each accepted equal pair; miss_cnt increments on each accepted unequal pair.
  - Both saturate at 2^CNT_W-1.
  - Both update on input accept, not on output drain.
- **Run detector:**
  - run_cnt is 8 bits and internal.
  - Accepted equal pair: run_cnt increments, saturating at RUN_LEN.
  - Accepted unequal pair: run_cnt resets to 0.
  - out_run_hit is registered with the result. It is 1 only for the pair that moves run_cnt from RUN_LEN-1 to RUN_LEN.
  - A further run of RUN_LEN needs a mismatch first, because run_cnt stays saturated.
- **clr:** on the next edge, match_cnt, miss_cnt and run_cnt go to 0.
  - If an accept coincides with clr, clear wins: the pair is not counted, its out_run_hit is 0, and run_cnt = 0 afterwards.
  - The pair's out_eq and out_diff_idx are still produced normally.
- **Reset (rst_n low, asynchronous, any time including mid-handshake):**
  - out_valid=0, out_eq=0, out_diff_idx=0, out_run_hit=0, match_cnt=0, miss_cnt=0, run_cnt=0.
  - in_ready reads 1 during and after reset.
  - A pending result is discarded.

## Timing
- Latency: pair accepted at edge N appears on the outputs after edge N, with out_valid=1 in cycle N+1.
- Throughput: one pair per cycle while out_ready is held 1.
- Counter visibility: match_cnt and miss_cnt reflect a pair from the cycle after its accept edge, coincident with its result.
- No combinational path from a, b or in_valid to any output. The only combinational path is out_ready -> in_ready.
- Reset release: synchronise rst_n deassertion externally. The first accept is legal on the first edge after release.

## Test plan
- **Reset defaults:** hold rst_n=0 for 3 cycles with in_valid=1. Required: out_valid=0, match_cnt=0, miss_cnt=0, in_ready=1.
- **Single compare:**
  - a=8'hA5, b=8'hA5, out_ready=1. Required: out_eq=1, out_diff_idx=0, match_cnt=1 one cycle later.
  - Then a=8'hA5, b=8'hA1. Required: out_eq=0, out_diff_idx=2, miss_cnt=1.
- **Back-pressure:** stream 3 pairs with out_ready=0 after the first accept. Required: in_ready=0, and out_eq/out_diff_idx hold the first pair's values. Raise out_ready: the remaining pairs emerge in order, one per cycle, with no loss or duplication.
- **Run detector (RUN_LEN=4):** send equal, equal, unequal, then 5 equal pairs. Required: out_run_hit=1 only on the 4th equal pair after the mismatch, 0 on the 5th. Final counters: match_cnt=7, miss_cnt=1.
- **Clear collision:** 3 equal pairs, then assert clr in the same cycle as a 4th equal accept. Required: match_cnt=0, out_run_hit=0, out_eq=1 for that result. A following equal pair gives match_cnt=1.
- **Saturation and mid-operation reset:**
  - With CNT_W=4, send 20 unequal pairs. Required: miss_cnt sticks at 15.
  - Assert rst_n=0 while out_valid=1 and out_ready=0. Required: out_valid drops immediately (asynchronous) and all counters read 0.
